bi_mem_initiator: RTL and testbench

- Initiator end of the basic BiMem memory interface: `enable`, `isWrite`, `addr`, `writeData`, `readData`, `hold`.
- Converts an upstream valid/ready request stream into memory accesses and returns read data on a valid/ready response stream.
- Honours memory back-pressure (`hold`) and buffers read responses in a small FIFO, so downstream stalls never lose data.
- Sits between any client logic (DMA, CPU port, test driver) and a BiMemImpl instance.

---
 rtl/bi_mem_initiator.sv | 152 +++++++++++++++
 tb/tb_bi_mem_initiator.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bi_mem_initiator.sv
// bi_mem_initiator: turns a valid/ready request stream into BiMem accesses.
// Read data comes back through a small first-word-fall-through response FIFO.
// Read credits are reserved when a request is accepted, so that FIFO can never overflow.
module bi_mem_initiator #(
  parameter int  WIDTH     = 16,
  parameter int  HEIGHT    = 16,
  parameter int  RSP_DEPTH = 2,
  localparam int AW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_isWrite_i,
  input  logic [AW-1:0]    req_addr_i,
  input  logic [WIDTH-1:0] req_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             mem_enable_o,
  output logic             mem_isWrite_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [WIDTH-1:0] mem_writeData_o,
  input  logic [WIDTH-1:0] mem_readData_i,
  input  logic             mem_hold_i,
  output logic             busy_o
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  // Wide enough for fifo_count + in-flight read + pending read command.
  localparam int RW = CW + 1;

  // Command register: this register drives the memory port directly.
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_iswrite_q, cmd_iswrite_d;
  logic [AW-1:0]    cmd_addr_q, cmd_addr_d;
  logic [WIDTH-1:0] cmd_data_q, cmd_data_d;

  // A read was accepted last cycle, so its data is on mem_readData_i now.
  logic             rd_inflight_q, rd_inflight_d;

  // Response FIFO state.
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] fifo_mem [RSP_DEPTH];

  logic          accept;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [RW-1:0] reads_reserved;
  logic          credit_ok;
  logic          req_fire;

  // Handshake, credit and FIFO control terms.
  always_comb begin
    accept         = cmd_valid_q && !mem_hold_i;
    fifo_empty     = (count_q == '0);
    push           = rd_inflight_q;
    pop            = !fifo_empty && rsp_ready_i;
    reads_reserved = RW'(count_q) + RW'(rd_inflight_q) + RW'(cmd_valid_q && !cmd_iswrite_q);
    // A slot popped in this cycle is already free for a new read.
    credit_ok      = (reads_reserved - RW'(pop)) < RW'(RSP_DEPTH);
    req_ready_o    = (!cmd_valid_q || !mem_hold_i) && (req_isWrite_i || credit_ok) && !rst_i;
    req_fire       = req_valid_i && req_ready_o;
  end

  // Next-state logic for the command register, the in-flight flag and the FIFO pointers.
  always_comb begin
    cmd_valid_d   = cmd_valid_q;
    cmd_iswrite_d = cmd_iswrite_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_data_d    = cmd_data_q;
    rd_inflight_d = accept && !cmd_iswrite_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (req_fire) begin
      cmd_valid_d   = 1'b1;
      cmd_iswrite_d = req_isWrite_i;
      cmd_addr_d    = req_addr_i;
      cmd_data_d    = req_data_i;
    end else if (accept) begin
      cmd_valid_d   = 1'b0;
    end

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Register state; reset clears everything, so any late read data is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_valid_q   <= 1'b0;
      cmd_iswrite_q <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_data_q    <= '0;
      rd_inflight_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      cmd_valid_q   <= cmd_valid_d;
      cmd_iswrite_q <= cmd_iswrite_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_data_q    <= cmd_data_d;
      rd_inflight_q <= rd_inflight_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Capture returning read data; the storage itself needs no reset.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      fifo_mem[wr_ptr_q] <= mem_readData_i;
    end
  end

  assign mem_enable_o    = cmd_valid_q;
  assign mem_isWrite_o   = cmd_iswrite_q;
  assign mem_addr_o      = cmd_addr_q;
  assign mem_writeData_o = cmd_data_q;

  // Show zero instead of stale storage while the FIFO is empty.
  assign rsp_valid_o = !fifo_empty;
  assign rsp_data_o  = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
  assign busy_o      = cmd_valid_q || rd_inflight_q || !fifo_empty;

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (count_q == CW'(RSP_DEPTH))));
  a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CW'(RSP_DEPTH));
  a_hold_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_enable_o && mem_hold_i) |=> (mem_enable_o && $stable(mem_isWrite_o) &&
                                      $stable(mem_addr_o) && $stable(mem_writeData_o)));

endmodule

// File: tb/tb_bi_mem_initiator.sv
// Testbench for bi_mem_initiator.
// A BiMem-like memory sits on the mem_* port.
// Expected read data comes from a shadow copy of memory, updated in request-handshake order.
module tb_bi_mem_initiator;
  localparam int W  = 16;
  localparam int H  = 16;
  localparam int D  = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, req_valid, req_ready, req_isWrite, rsp_valid, rsp_ready;
  logic [AW-1:0] req_addr, mem_addr;
  logic [W-1:0]  req_data, rsp_data, mem_wdata, mem_rdata;
  logic          mem_enable, mem_isWrite, mem_hold, busy;

  always #5 clk = ~clk;

  bi_mem_initiator #(.WIDTH(W), .HEIGHT(H), .RSP_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_isWrite_i(req_isWrite),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .mem_enable_o(mem_enable), .mem_isWrite_o(mem_isWrite), .mem_addr_o(mem_addr),
    .mem_writeData_o(mem_wdata), .mem_readData_i(mem_rdata), .mem_hold_i(mem_hold),
    .busy_o(busy)
  );

  // Memory behind the port: an access completes when it is enabled and not held.
  // Read data is registered, so it appears one cycle after the access completes.
  logic [W-1:0] phys_mem [H];
  logic [W-1:0] fill_val [H];
  logic         fill_en;
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < H; i++) phys_mem[i] <= fill_val[i];
    end else if (mem_enable && !mem_hold) begin
      if (mem_isWrite) phys_mem[mem_addr] <= mem_wdata;
      else             mem_rdata <= phys_mem[mem_addr];
    end
  end

  // Reference model: memory contents as seen by the request stream, plus the expected responses.
  logic [W-1:0] ref_mem [H];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hold_left = 0;
  int en_total = 0;
  int last_rsp_cyc = -1;
  int s_cyc;
  logic s_req_ready, s_enable, s_hold, s_busy, s_req_hs, s_rsp_hs;
  logic [AW-1:0] s_addr;

  // One clock: apply the hold schedule, sample the outputs mid-cycle,
  // update the model, then step to 1 ns after the next rising edge.
  task automatic cycle();
    mem_hold = (hold_left > 0) && mem_enable;
    if (mem_hold) hold_left--;
    #1;
    s_cyc = cyc;
    s_req_ready = req_ready; s_enable = mem_enable; s_addr = mem_addr;
    s_hold = mem_hold; s_busy = busy;
    if (mem_enable) en_total++;
    s_req_hs = req_valid && req_ready;
    if (s_req_hs) begin
      if (req_isWrite) ref_mem[req_addr] = req_data;
      else             exp_q.push_back(ref_mem[req_addr]);
    end
    s_rsp_hs = rsp_valid && rsp_ready;
    if (s_rsp_hs) begin
      obs_q.push_back(rsp_data);
      last_rsp_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold one request until it is accepted, or until the cycle budget runs out.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d, output logic ok);
    req_valid = 1'b1; req_isWrite = w; req_addr = a; req_data = d; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cycle();
      ok = s_req_hs;
    end
    req_valid = 1'b0;
  endtask

  // Let all outstanding work finish with the response side always ready.
  task automatic drain(output logic ok);
    req_valid = 1'b0; rsp_ready = 1'b1; ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      cycle();
      ok = !s_busy;
    end
  endtask

  task automatic test_reset();
    // Present a write request while reset is held; it must not be accepted.
    req_valid = 1'b1; req_isWrite = 1'b1; req_addr = 4'd7; req_data = 16'h1234;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b, expected 0", req_ready); end
    n_checks++; if (mem_enable !== 1'b0) begin n_fail++; $display("FAIL reset_mem_enable: got %b, expected 0", mem_enable); end
    n_checks++; if (mem_isWrite !== 1'b0) begin n_fail++; $display("FAIL reset_mem_isWrite: got %b, expected 0", mem_isWrite); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h, expected 0", mem_addr); end
    n_checks++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata: got %0h, expected 0", mem_wdata); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, expected 0", rsp_valid); end
    n_checks++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %0h, expected 0", rsp_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    @(posedge clk); #1;
    cyc++;
    fill_en = 1'b0; rst = 1'b0; req_valid = 1'b0; req_isWrite = 1'b0;
    #1;
    // Once out of reset and idle, a read has credit and must be ready.
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b, expected 1", req_ready); end
  endtask

  task automatic test_single();
    logic ok; int hs_cyc; int en0;
    rsp_ready = 1'b1; en0 = en_total;
    issue(1'b1, 4'd3, 16'hBEEF, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_write_hs: got %b, expected 1", ok); end
    issue(1'b0, 4'd3, 16'h0000, ok);
    hs_cyc = s_cyc;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_read_hs: got %b, expected 1", ok); end
    drain(ok);
    n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL single_rsp_count: got %0d, expected 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q[0] !== 16'hBEEF) begin n_fail++; $display("FAIL single_rsp_data: got %0h, expected beef", obs_q[0]); end
    end
    // The data appears two clock edges after the handshake edge,
    // so it is seen in the third sampled cycle after the handshake.
    n_checks++; if (last_rsp_cyc !== hs_cyc + 3) begin n_fail++; $display("FAIL single_latency: got cycle %0d, expected %0d", last_rsp_cyc, hs_cyc + 3); end
    n_checks++; if (en_total - en0 !== 2) begin n_fail++; $display("FAIL single_enable_cycles: got %0d, expected 2", en_total - en0); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic ok; int c0; int en0; int nacc = 0;
    rsp_ready = 1'b1; en0 = en_total; c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, AW'(i), 16'($urandom), ok);
      if (ok) nacc++;
    end
    // Writes need no credit, so eight writes take eight cycles.
    n_checks++; if (cyc - c0 !== 8 || nacc !== 8) begin n_fail++; $display("FAIL b2b_write_cycles: got %0d cycles %0d accepted, expected 8 and 8", cyc - c0, nacc); end
    c0 = cyc; nacc = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, AW'(i), 16'h0, ok);
      if (ok) nacc++;
    end
    // With two credits and a popping consumer, reads go through in at least two of every three cycles.
    n_checks++; if (cyc - c0 > 12 || nacc !== 8) begin n_fail++; $display("FAIL b2b_read_cycles: got %0d cycles %0d accepted, expected <=12 and 8", cyc - c0, nacc); end
    drain(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: got %b, expected 1", ok); end
    n_checks++; if (en_total - en0 !== 16) begin n_fail++; $display("FAIL b2b_accesses: got %0d, expected 16", en_total - en0); end
    n_checks++; if (obs_q.size() !== 8) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d, expected 8", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got %0h, expected %0h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_hold_stretch();
    logic ok; logic wr_ok = 1'b0; int addr5 = 0; int held = 0; int bad_ready = 0;
    rsp_ready = 1'b1;
    hold_left = 3;
    issue(1'b0, 4'd5, 16'h0, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hold_read_hs: got %b, expected 1", ok); end
    // A write waits behind the held read; it must not be accepted while the read is held.
    req_valid = 1'b1; req_isWrite = 1'b1; req_addr = 4'd9; req_data = 16'($urandom);
    for (int i = 0; i < 12 && !wr_ok; i++) begin
      cycle();
      if (s_enable && s_addr == 4'd5) addr5++;
      if (s_enable && s_hold) held++;
      if (s_enable && s_hold && s_req_ready) bad_ready++;
      wr_ok = s_req_hs;
    end
    req_valid = 1'b0;
    drain(ok);
    n_checks++; if (addr5 !== 4) begin n_fail++; $display("FAIL hold_addr_cycles: got %0d, expected 4", addr5); end
    n_checks++; if (held !== 3) begin n_fail++; $display("FAIL hold_cycles: got %0d, expected 3", held); end
    n_checks++; if (bad_ready !== 0) begin n_fail++; $display("FAIL hold_ready_low: got %0d ready cycles, expected 0", bad_ready); end
    n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL hold_rsp_count: got %0d, expected 1", obs_q.size()); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      n_checks++; if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL hold_rsp_data: got %0h, expected %0h", obs_q[0], exp_q[0]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic ok; int nacc = 0;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_isWrite = 1'b0; req_addr = 4'd10; req_data = 16'h0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_req_hs) begin nacc++; req_addr = req_addr + 4'd1; end
    end
    n_checks++; if (nacc !== D) begin n_fail++; $display("FAIL bp_accepted: got %0d, expected %0d", nacc, D); end
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_read_ready: got %b, expected 0", req_ready); end
    req_isWrite = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_write_ready: got %b, expected 1", req_ready); end
    issue(1'b1, 4'd14, 16'($urandom), ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_write_hs: got %b, expected 1", ok); end
    rsp_ready = 1'b1;
    for (int i = nacc; i < 4; i++) begin
      issue(1'b0, AW'(10 + i), 16'h0, ok);
    end
    drain(ok);
    n_checks++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL bp_rsp_count: got %0d, expected 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_rsp[%0d]: got %0h, expected %0h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_full_push_pop();
    logic ok;
    rsp_ready = 1'b0;
    issue(1'b0, 4'd1, 16'h0, ok);
    issue(1'b0, 4'd2, 16'h0, ok);
    repeat (3) cycle();
    n_checks++; if (rsp_valid !== 1'b1 || obs_q.size() !== 0) begin n_fail++; $display("FAIL full_hold: got valid %b pops %0d, expected 1 and 0", rsp_valid, obs_q.size()); end
    // Start draining the full FIFO while more reads are accepted into the slots being freed.
    rsp_ready = 1'b1;
    issue(1'b0, 4'd4, 16'h0, ok);
    issue(1'b0, 4'd6, 16'h0, ok);
    drain(ok);
    n_checks++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL full_rsp_count: got %0d, expected 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_rsp[%0d]: got %0h, expected %0h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic ok; int nacc = 0;
    for (int t = 0; t < 60; t++) begin
      req_valid = 1'b1; req_isWrite = 1'($urandom_range(0, 1));
      req_addr = AW'($urandom_range(0, H - 1)); req_data = 16'($urandom);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        if (hold_left == 0 && $urandom_range(0, 5) == 0) hold_left = $urandom_range(1, 2);
        cycle();
        ok = s_req_hs;
      end
      if (ok) nacc++;
    end
    req_valid = 1'b0;
    drain(ok);
    n_checks++; if (nacc !== 60 || ok !== 1'b1) begin n_fail++; $display("FAIL rand_progress: got %0d accepted drain %b, expected 60 and 1", nacc, ok); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_rsp_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_rsp[%0d]: got %0h, expected %0h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_op();
    logic ok; int seen = 0;
    rsp_ready = 1'b1;
    issue(1'b0, 4'd2, 16'h0, ok);
    // The read is accepted in this cycle while a write is handed over behind it.
    req_valid = 1'b1; req_isWrite = 1'b1; req_addr = 4'd8; req_data = 16'($urandom);
    cycle();
    req_valid = 1'b0;
    // Next cycle: the read is in flight, the write is held, and reset arrives.
    hold_left = 1; rst = 1'b1;
    cycle();
    n_checks++; if (s_req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_req_ready: got %b, expected 0", s_req_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (mem_enable !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_enable: got %b, expected 0", mem_enable); end
    n_checks++; if ({mem_isWrite, mem_addr, mem_wdata} !== '0) begin n_fail++; $display("FAIL midrst_mem_outputs: got %0h, expected 0", {mem_isWrite, mem_addr, mem_wdata}); end
    n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0) begin n_fail++; $display("FAIL midrst_rsp: got valid %b data %0h, expected 0 and 0", rsp_valid, rsp_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (rsp_valid) seen++;
    end
    n_checks++; if (obs_q.size() !== 0 || seen !== 0) begin n_fail++; $display("FAIL midrst_late_data: got %0d responses, expected 0", obs_q.size() + seen); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    rst = 1'b1; fill_en = 1'b1; mem_hold = 1'b0; rsp_ready = 1'b0;
    req_valid = 1'b0; req_isWrite = 1'b0; req_addr = '0; req_data = '0;
    for (int i = 0; i < H; i++) begin
      fill_val[i] = 16'($urandom);
      ref_mem[i]  = fill_val[i];
    end
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_stretch();
    test_backpressure();
    test_full_push_pop();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
